// File: rtl/shift_reg_bank.sv
// rtl/shift_reg_bank.sv - universal shift register with preset, parallel load and fill tracking
// full reports that every bit of q has been written since the last reset.
module shift_reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_msb_in,
  input  logic             ser_lsb_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             ser_lsb_out,
  output logic             ser_msb_out,
  output logic             full
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] next_q;
  logic [CW-1:0]    fill;
  logic [CW-1:0]    next_fill;
  logic [CW-1:0]    fill_inc;

  // Shifts only ever add defined bits, so the count saturates instead of wrapping.
  assign fill_inc = (fill == FILL_MAX) ? fill : fill + CW'(1);

  always_comb begin
    next_q    = q;
    next_fill = fill;
    if (set) begin
      next_q    = '1;
      next_fill = FILL_MAX;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          next_q    = q;
          next_fill = fill;
        end
        MODE_SHR: begin
          next_q    = {ser_msb_in, q[WIDTH-1:1]};
          next_fill = fill_inc;
        end
        MODE_SHL: begin
          next_q    = {q[WIDTH-2:0], ser_lsb_in};
          next_fill = fill_inc;
        end
        MODE_LOAD: begin
          next_q    = d;
          next_fill = FILL_MAX;
        end
        default: begin
          next_q    = q;
          next_fill = fill;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      fill <= '0;
      full <= 1'b0;
    end else begin
      q    <= next_q;
      fill <= next_fill;
      full <= (next_fill == FILL_MAX);
    end
  end

  assign qb          = ~q;
  assign ser_lsb_out = q[0];
  assign ser_msb_out = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_bank.sv
// tb/tb_shift_reg_bank.sv - directed and random checks of shift_reg_bank against a behavioural model
module tb_shift_reg_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d = 8'h00;
  logic       ser_msb_in = 1'b0;
  logic       ser_lsb_in = 1'b0;
  logic [7:0] q;
  logic [7:0] qb;
  logic       ser_lsb_out;
  logic       ser_msb_out;
  logic       full;

  int total = 0;
  int bad = 0;

  logic [7:0] mq;
  int         mfill;

  shift_reg_bank #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .set(set), .en(en), .mode(mode), .d(d),
    .ser_msb_in(ser_msb_in), .ser_lsb_in(ser_lsb_in),
    .q(q), .qb(qb), .ser_lsb_out(ser_lsb_out), .ser_msb_out(ser_msb_out), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] mqb;
    mqb = ~mq;
    chk({tag, ".q"}, q, mq);
    chk({tag, ".qb"}, qb, mqb);
    chk({tag, ".lsb_out"}, {7'b0, ser_lsb_out}, {7'b0, mq[0]});
    chk({tag, ".msb_out"}, {7'b0, ser_msb_out}, {7'b0, mq[7]});
    chk({tag, ".full"}, {7'b0, full}, {7'b0, (mfill >= 8)});
  endtask

  // Model: set forces all ones, shifts add one written bit, loads write every bit.
  task automatic step(input logic s, input logic e, input logic [1:0] m,
                      input logic [7:0] dd, input logic mi, input logic li);
    set = s; en = e; mode = m; d = dd; ser_msb_in = mi; ser_lsb_in = li;
    @(posedge clk);
    #1;
    if (s) begin
      mq = 8'hFF; mfill = 8;
    end else if (e) begin
      if (m == 2'd1) begin
        mq = (mq >> 1) | (mi ? 8'h80 : 8'h00); mfill++;
      end else if (m == 2'd2) begin
        mq = (mq << 1) | {7'b0, li}; mfill++;
      end else if (m == 2'd3) begin
        mq = dd; mfill = 8;
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    mq = 8'h00; mfill = 0;
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    mq = 8'h00; mfill = 0;
    #2;
    check_all("reset_state");
    // Edge while reset is high must not load anything.
    set = 1'b1; en = 1'b1; mode = 2'd3; d = 8'h3C;
    @(posedge clk);
    #1;
    check_all("reset_blocks_edge");
    reset = 1'b0;
    set = 1'b0;

    step(0, 1, 2'd3, 8'hA5, 0, 0);
    check_all("load_a5");

    pulse_reset("reset_before_shr");
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'd1, 8'h00, 1, 0);
      check_all($sformatf("shr_fill_%0d", i));
    end
    step(0, 1, 2'd1, 8'h00, 0, 0);
    check_all("shr_ninth");

    step(0, 1, 2'd3, 8'h81, 0, 0);
    step(0, 1, 2'd2, 8'h00, 0, 0);
    check_all("shl_81");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'd2, 8'hFF, 1, 1);
      check_all($sformatf("en_low_hold_%0d", i));
    end

    pulse_reset("reset_before_set");
    step(1, 1, 2'd3, 8'h00, 0, 0);
    check_all("set_over_load");
    step(0, 1, 2'd3, 8'h12, 0, 0);
    step(1, 0, 2'd0, 8'h00, 0, 0);
    check_all("set_en_low");

    pulse_reset("reset_before_mid");
    for (int i = 0; i < 4; i++) step(0, 1, 2'd1, 8'h00, 1, 0);
    check_all("four_shifts_f0");
    pulse_reset("reset_mid_shift");
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'd1, 8'h00, 1, 0);
      check_all($sformatf("refill_%0d", i));
    end

    pulse_reset("reset_before_alt");
    for (int i = 0; i < 8; i++) begin
      step(0, 1, (i % 2 == 0) ? 2'd1 : 2'd2, 8'h00, 1'($urandom), 1'($urandom));
      check_all($sformatf("alt_dir_%0d", i));
    end

    pulse_reset("reset_before_random");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset($sformatf("rand_reset_%0d", i));
      step(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
      check_all($sformatf("rand_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_bank.md
SHIFT_REG_BANK -- requirements
Module: shift_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port set  input  1  synchronous preset, active-high.
REQ-005 The block SHALL have port en  input  1  clock enable for mode operations.
REQ-006 The block SHALL have port mode  input  2  operation select: 00 hold, 01 shift toward LSB, 10 shift toward MSB, 11 parallel load.
REQ-007 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-008 The block SHALL have port ser_msb_in  input  1  serial bit entering at bit WIDTH-1 on shift toward LSB.
REQ-009 The block SHALL have port ser_lsb_in  input  1  serial bit entering at bit 0 on shift toward MSB.
REQ-010 The block SHALL have port q  output  WIDTH  register contents.
REQ-011 The block SHALL have port qb  output  WIDTH  bitwise complement of q.
REQ-012 The block SHALL have port ser_lsb_out  output  1  equals q[0].
REQ-013 The block SHALL have port ser_msb_out  output  1  equals q[WIDTH-1].
REQ-014 The block SHALL have port full  output  1  high when every bit of q has been defined since the last reset.

Function
REQ-015 Update priority SHALL be: reset > set > en low > mode.
REQ-016 set high at a clk edge SHALL make q all ones, irrespective of en and mode.
REQ-017 en low with set low SHALL hold q and the fill count unchanged.
REQ-018 mode 00 with en high SHALL hold q and the fill count.
REQ-019 mode 01 with en high SHALL load q <= {ser_msb_in, q[WIDTH-1:1]}.
REQ-020 mode 10 with en high SHALL load q <= {q[WIDTH-2:0], ser_lsb_in}.
REQ-021 mode 11 with en high SHALL load q <= d.
REQ-022 qb, ser_lsb_out and ser_msb_out SHALL be combinational from q, with zero added latency.
REQ-023 An internal fill counter of width clog2(WIDTH+1) SHALL count serial shifts since reset; it increments by 1 on each executed shift (mode 01 or 10) and saturates at WIDTH with no wrap.
REQ-024 Parallel load or set SHALL force the fill counter to WIDTH.
REQ-025 full SHALL equal (fill counter == WIDTH), registered: it asserts in the cycle after the edge that reaches WIDTH.
REQ-026 Shifts in either direction SHALL count identically; mixing directions does not decrement.
REQ-027 Once full, the block SHALL remain full until reset, regardless of further shifts, loads or holds.
REQ-028 A mode change between consecutive edges SHALL take effect at the next edge with no pipeline bubble.

Reset
REQ-029 reset high SHALL immediately, without waiting for clk, force q = 0, qb = all ones, ser_lsb_out = 0, ser_msb_out = 0, fill counter = 0, full = 0.
REQ-030 While reset is high, set, en, mode and clk edges SHALL have no effect.
REQ-031 Reset asserted mid-operation (e.g. partway through a shift sequence) SHALL discard contents and the fill count; operation resumes at the first clk edge after deassertion.
REQ-032 Deassertion of reset coincident with a clk edge SHALL leave the state at reset values for that edge.

Verification (WIDTH = 8)
REQ-033 Reset then mode 11, d = 8'hA5, one edge -> q = 8'hA5, qb = 8'h5A, full = 1, ser_msb_out = 1, ser_lsb_out = 1.
REQ-034 Reset then mode 01, ser_msb_in = 1 for 8 edges -> q steps 80, C0, ... FF; full = 0 after 7 edges, 1 after the 8th; a 9th shift with ser_msb_in = 0 gives q = 7F, full stays 1.
REQ-035 q = 8'h81, mode 10, ser_lsb_in = 0, one edge -> q = 8'h02, ser_msb_out = 0; then en = 0 for 3 edges -> q stays 8'h02.
REQ-036 set = 1 with mode 11, d = 8'h00, en = 1 -> q = 8'hFF, full = 1; set = 1 with en = 0 -> q = 8'hFF.
REQ-037 After 4 shifts (q = 8'hF0 via mode 01, ser_msb_in = 1), reset pulsed between clk edges -> q = 0 and full = 0 before the next edge; 8 further shifts are required to reach full.
REQ-038 Alternate mode 01 and 10 for 8 edges from reset -> full = 1 after the 8th edge, proving both directions count.
